// File: rtl/pwm_tick_generator.sv
// pwm_tick_generator: tick-driven PWM with double-buffered duty.
// Duty changes land on period boundaries so the waveform never glitches.
module pwm_tick_generator #(
  parameter int R = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         en,
  input  logic [R:0]   duty_in,
  input  logic         duty_load,
  output logic         pwm_out,
  output logic         period_start,
  output logic         duty_pending
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [R:0]   FULL = {1'b1, {R{1'b0}}};
  localparam logic [R-1:0] CMAX = '1;

  state_t       state, state_n;
  logic [R-1:0] cnt, cnt_n;
  logic [R:0]   duty_active, act_n;
  logic [R:0]   duty_shadow, sh_n;
  logic         pend_n;
  logic         ps_n;
  logic         pwm_n;
  logic         wrap;
  logic         apply;

  // next-state: counter, FSM, shadow capture and boundary apply
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    act_n   = duty_active;
    sh_n    = duty_shadow;
    pend_n  = duty_pending;
    ps_n    = 1'b0;
    wrap    = (state == RUN) && en
            && tick && (cnt == CMAX);
    apply   = duty_pending
            && ((state == IDLE) || wrap);

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = RUN;
          ps_n    = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = cnt + 1'b1;
          ps_n  = (cnt == CMAX);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // apply uses the old shadow; a same-edge load stays pending
    if (apply) begin
      act_n  = duty_shadow;
      pend_n = 1'b0;
    end

    if (duty_load) begin
      sh_n   = (duty_in > FULL) ? FULL : duty_in;
      pend_n = 1'b1;
    end

    pwm_n = (state_n == RUN)
          && ({1'b0, cnt_n} < act_n);
  end

  // single register bank: FSM, counter, duty buffers, outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      duty_active  <= '0;
      duty_shadow  <= '0;
      duty_pending <= 1'b0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      duty_active  <= act_n;
      duty_shadow  <= sh_n;
      duty_pending <= pend_n;
      pwm_out      <= pwm_n;
      period_start <= ps_n;
    end
  end

endmodule

// File: tb/tb_pwm_tick_generator.sv
// tb_pwm_tick_generator: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural PWM model.
module tb_pwm_tick_generator;

  localparam int R    = 8;
  localparam int TOP  = 1 << R;

  logic         clk;
  logic         reset_n;
  logic         tick;
  logic         en;
  logic [R:0]   duty_in;
  logic         duty_load;
  logic         pwm_out;
  logic         period_start;
  logic         duty_pending;

  int n_cmp;
  int n_bad;

  // model state
  bit m_run;
  int m_cnt;
  int m_act;
  int m_sh;
  bit m_pend;
  bit m_ps;

  pwm_tick_generator #(.R(R)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .en           (en),
    .duty_in      (duty_in),
    .duty_load    (duty_load),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 0;
    m_cnt  = 0;
    m_act  = 0;
    m_sh   = 0;
    m_pend = 0;
    m_ps   = 0;
  endtask

  // one clock edge of the reference behaviour
  task automatic model_edge(
    input bit t, input bit e,
    input bit l, input int d
  );
    bit wrap_now;
    wrap_now = 0;
    m_ps = 0;
    if (!m_run) begin
      if (m_pend) begin
        m_act  = m_sh;
        m_pend = 0;
      end
      m_cnt = 0;
      if (e) begin
        m_run = 1;
        m_ps  = 1;
      end
    end else if (!e) begin
      m_run = 0;
      m_cnt = 0;
    end else if (t) begin
      if (m_cnt == TOP - 1) begin
        m_cnt    = 0;
        m_ps     = 1;
        wrap_now = 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (wrap_now && m_pend) begin
      m_act  = m_sh;
      m_pend = 0;
    end
    if (l) begin
      m_sh   = (d > TOP) ? TOP : d;
      m_pend = 1;
    end
  endtask

  function automatic bit exp_pwm();
    return m_run && (m_cnt < m_act);
  endfunction

  task automatic check_outs();
    check("pwm", 32'(pwm_out), 32'(exp_pwm()));
    check("pstart", 32'(period_start), 32'(m_ps));
    check("pend", 32'(duty_pending), 32'(m_pend));
  endtask

  // check, drive for one edge, advance the model
  task automatic cyc(
    input bit t, input bit e,
    input bit l, input int d
  );
    @(negedge clk);
    check_outs();
    tick      = t;
    en        = e;
    duty_load = l;
    duty_in   = (R+1)'(d);
    @(posedge clk);
    model_edge(t, e, l, d);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, 0, 0);
  endtask

  // tick until the model counter reaches c while running
  task automatic run_until(input int c);
    int k;
    k = 0;
    while (!(m_run && m_cnt == c) && k < 2 * TOP) begin
      cyc(1, 1, 0, 0);
      k++;
    end
    check("reach_cnt", 32'(m_cnt), 32'(c));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    check_outs();
    tick      = 1;
    en        = 1;
    duty_load = 0;
    #2 reset_n = 0;
    #1;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_ps", 32'(period_start), 32'd0);
    check("rst_pend", 32'(duty_pending), 32'd0);
    model_reset();
    #1 reset_n = 1;
    @(posedge clk);
    model_edge(1, 1, 0, 0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    tick      = 1'b0;
    en        = 1'b0;
    duty_load = 1'b0;
    duty_in   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);
    check("reset_pend", 32'(duty_pending), 32'd0);
    reset_n = 1'b1;

    // load 64 with enable: first period low, then 64/192
    cyc(1, 1, 1, 64);
    run(3 * TOP);

    // duty 0 for one period, then duty 256
    run_until(10);
    cyc(1, 1, 1, 0);
    run(TOP);
    run_until(10);
    cyc(1, 1, 1, 256);
    run(2 * TOP + 20);

    // saturating load while idle
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 300);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // two mid-period loads, then a load on the wrap edge
    cyc(1, 1, 0, 0);
    run_until(20);
    cyc(1, 1, 1, 10);
    run_until(100);
    cyc(1, 1, 1, 200);
    run_until(TOP - 1);
    cyc(1, 1, 1, 50);
    run(2 * TOP + 5);

    // drop enable mid-period with output high
    cyc(1, 1, 1, 200);
    run_until(TOP - 1);
    run_until(100);
    check("pwm_hi_100", 32'(pwm_out), 32'd1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("drop_pwm", 32'(pwm_out), 32'd0);
    cyc(1, 1, 0, 0);
    run(40);

    // async reset with a pending load
    run_until(50);
    cyc(1, 1, 1, 77);
    cyc(1, 1, 0, 0);
    reset_pulse();
    run(TOP + 10);

    // random traffic
    for (int i = 0; i < 8000; i++) begin
      cyc(($urandom % 4) != 0,
          ($urandom % 64) != 0,
          ($urandom % 40) == 0,
          int'($urandom % 512));
    end
    @(negedge clk);
    check_outs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
